// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, boots from the reset vector, loads the interrupt
// vector, restores popped PCs and fills the IF/ID register feeding the control unit.
module fetch_unit #(
  parameter int PC_WIDTH       = 32,
  parameter int INSTR_WIDTH    = 16,
  parameter int IMEM_AW        = 20,
  parameter int RESET_VEC_ADDR = 0,
  parameter int INT_VEC_ADDR   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_AW-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic [1:0]             pc_sel,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   fetch_pc_enable,
  input  logic                   freeze_cu,
  input  logic                   flush,
  input  logic                   pop_pc2,
  input  logic                   pop_pc1,
  input  logic [15:0]            stack_rdata,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_next,
  output logic                   if_id_valid
);

  typedef enum logic [2:0] {BOOT_HI, BOOT_LO, RUN, VEC_HI, VEC_LO} state_t;

  localparam logic [INSTR_WIDTH-1:0] NOP = '0;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc;
  logic [15:0]            pop_hi_q, pop_hi_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_next_q, pc_next_d;
  logic                   valid_q, valid_d;
  logic                   kill_ifid;

  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign kill_ifid = flush || (pc_sel == 2'b11) || pop_pc1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pop_hi_d  = pop_hi_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    imem_addr = pc_q[IMEM_AW-1:0];
    case (state_q)
      BOOT_HI: begin
        imem_addr            = IMEM_AW'(RESET_VEC_ADDR);
        pc_d[PC_WIDTH-1:16]  = imem_data;
        instr_d              = NOP;
        valid_d              = 1'b0;
        state_d              = BOOT_LO;
      end
      BOOT_LO: begin
        imem_addr   = IMEM_AW'(RESET_VEC_ADDR + 1);
        pc_d[15:0]  = imem_data;
        instr_d     = NOP;
        valid_d     = 1'b0;
        state_d     = RUN;
      end
      VEC_HI: begin
        imem_addr            = IMEM_AW'(INT_VEC_ADDR);
        pc_d[PC_WIDTH-1:16]  = imem_data;
        instr_d              = NOP;
        valid_d              = 1'b0;
        state_d              = VEC_LO;
      end
      VEC_LO: begin
        imem_addr   = IMEM_AW'(INT_VEC_ADDR + 1);
        pc_d[15:0]  = imem_data;
        instr_d     = NOP;
        valid_d     = 1'b0;
        state_d     = RUN;
      end
      RUN: begin
        // pop_pc1 uses the previously latched high half even if pop_pc2 is also set
        if (pop_pc1)                pc_d     = {pop_hi_q, stack_rdata};
        else if (pop_pc2)           pop_hi_d = stack_rdata;
        else if (pc_sel == 2'b11)   pc_d     = branch_target;
        else if (pc_sel == 2'b10)   state_d  = VEC_HI;
        else if (fetch_pc_enable)   pc_d     = pc_inc;

        if (kill_ifid) begin
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (!freeze_cu) begin
          instr_d   = imem_data;
          pc_next_d = pc_inc;
          valid_d   = 1'b1;
        end
      end
      default: state_d = BOOT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT_HI;
      pc_q      <= '0;
      pop_hi_q  <= '0;
      instr_q   <= NOP;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pop_hi_q  <= pop_hi_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  assign pc            = pc_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc_next = pc_next_q;
  assign if_id_valid   = valid_q;

endmodule
